systimer_tick_ctrl: RTL and testbench
=====================================

Name: systimer_tick_ctrl

Overview:
- Avalon-MM master sequencer that owns the 16-bit-register interval timer: programs period and control, services its timeout IRQ, and takes counter snapshots.
- Turns the timer into a clean system tick (single-cycle pulse plus tick counter) for the rest of the core.
- Sits between the timer's s1 slave and core logic, so no CPU software is needed to run the system tick.

Parameters:
- DEFAULT_PERIOD, 49999, 32-bit raw period loaded after reset when AUTO_START=1; tick interval is value+1 clocks.
- AUTO_START, 1, 1 = start the timer automatically after reset release; 0 = wait for cfg_load.
- TICK_CNT_W, 32, width of tick_count.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; 0 stops the timer and holds the controller idle
- cfg_period  in  32  raw period, sampled on the cfg_load cycle
- cfg_load  in  1  pulse; reprogram the period and restart
- snap_req  in  1  pulse; request a counter snapshot
- tmr_address  out  3  timer register address
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  timer write strobe, active-low
- tmr_writedata  out  16  timer write data
- tmr_readdata  in  16  timer read data, registered, valid 1 cycle after the address is presented
- tmr_irq  in  1  timer interrupt, level
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_CNT_W  serviced timeouts, wraps modulo 2^TICK_CNT_W
- snap_value  out  32  last captured counter value
- snap_valid  out  1  one-cycle pulse when snap_value updates
- busy  out  1  high in every state except IDLE and RUN

Behaviour:
- Reset (async): all outputs 0, tmr_write_n=1, tmr_chipselect=0, period latch = DEFAULT_PERIOD, pending flags cleared, state IDLE.
- Timer register map: 0 status (any write clears timeout), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- Each bus access occupies exactly one cycle; the slave has no waitrequest.
- FSM states and transitions:
  - IDLE: if enable and (AUTO_START first exit after reset, or load pending) -> WR_PL; otherwise stay.
  - WR_PL: write period[15:0] to address 2 -> WR_PH.
  - WR_PH: write period[31:16] to address 3 -> WR_CTRL. Writing the period force-stops the timer.
  - WR_CTRL: write 0x0007 to address 1 (START|CONT|ITO) -> WR_CLR0.
  - WR_CLR0: write 0 to address 0 to clear any stale timeout; no tick is generated -> RUN.
  - RUN: evaluated in priority order:
    - enable=0 -> WR_STOP.
    - load pending -> WR_PL.
    - tmr_irq=1 -> WR_CLR.
    - snap pending -> WR_SNAP.
  - WR_CLR: write 0 to address 0; tick=1 this cycle; tick_count+1 -> RUN.
  - WR_SNAP: write 0 to address 4 -> RD_L.
  - RD_L: present address 4 as a read (chipselect=1, write_n=1) -> RD_H.
  - RD_H: present address 5; capture tmr_readdata into snap low half -> RD_DONE.
  - RD_DONE: capture tmr_readdata into the high half; snap_valid=1 -> RUN.
  - WR_STOP: write 0x0008 to address 1 -> IDLE.
- Pending flags and requests:
  - cfg_load latches cfg_period and sets load pending in any state. A later cfg_load overwrites the latched period; the last one wins.
  - Load pending clears on entry to WR_PL.
  - snap_req sets snap pending; clears on entry to WR_SNAP. Multiple requests before service collapse to one.
- IRQ during a snapshot or reprogram sequence is not lost: the timer holds the timeout and it is serviced on the next RUN cycle.
- Outside write/read states, tmr_chipselect=0 and tmr_write_n=1.
- Tick latency: tmr_irq rising while in RUN -> tick asserted in the next cycle (the WR_CLR cycle).
- After WR_CLR, tmr_irq is low by the following RUN cycle; no double tick.
- enable falling mid-sequence completes the current sequence, then RUN -> WR_STOP.
- tick_count is not reset by reprogramming, only by reset_n.

Test Plan:
- Reset with AUTO_START=1, enable=1 -> bus writes (2,0xC34F), (3,0x0000), (1,0x0007), (0,x) on consecutive cycles; busy=1 for 4 cycles.
- Model timer with period 9 -> tick every 10 clocks; tick_count reaches 5 after 5 timeouts; exactly one tick per timeout.
- cfg_load with 0x0001_0000 while in RUN -> writes (2,0x0000), (3,0x0001), (1,0x0007), (0,x); subsequent ticks 65537 clocks apart.
- snap_req with model counter at 0x0002_1234 -> write addr 4, reads addr 4 then 5; snap_value=0x00021234 with a snap_valid pulse 4 cycles after the WR_SNAP entry.
- snap_req and irq in the same RUN cycle -> WR_CLR (tick) first, then the snapshot sequence; both complete; tick_count+1.
- enable=0 in RUN -> single write (1,0x0008), then IDLE. Assert reset_n mid-snapshot -> all outputs 0 immediately and the bus is released.

Source files
------------

// File: rtl/systimer_tick_ctrl.sv
// systimer_tick_ctrl: Avalon-MM sequencer that runs a 16-bit-register interval
// timer and turns its timeout IRQ into a single-cycle system tick plus counter.
module systimer_tick_ctrl #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TICK_CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [31:0]           cfg_period,
    input  logic                  cfg_load,
    input  logic                  snap_req,
    output logic [2:0]            tmr_address,
    output logic                  tmr_chipselect,
    output logic                  tmr_write_n,
    output logic [15:0]           tmr_writedata,
    input  logic [15:0]           tmr_readdata,
    input  logic                  tmr_irq,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic [31:0]           snap_value,
    output logic                  snap_valid,
    output logic                  busy
);

    localparam logic [2:0]  ADDR_STATUS   = 3'd0;
    localparam logic [2:0]  ADDR_CONTROL  = 3'd1;
    localparam logic [2:0]  ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0]  ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0]  ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0]  ADDR_SNAP_H   = 3'd5;
    localparam logic [15:0] CTRL_RUN      = 16'h0007;  // START | CONT | ITO
    localparam logic [15:0] CTRL_STOP     = 16'h0008;

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, WR_CLR0, RUN,
        WR_CLR, WR_SNAP, RD_L, RD_H, RD_DONE, WR_STOP
    } state_t;

    // Registered bus-side outputs, loaded together on every state change
    typedef struct packed {
        logic        busy;
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } bus_t;

    state_t      state_q;
    bus_t        bus_q;
    logic [31:0] period_q;
    logic [31:0] period_nxt;
    logic        load_pend;
    logic        snap_pend;
    logic        auto_pend;

    // Bus drive for the cycle spent in state s
    function automatic bus_t bus_for(input state_t s, input logic [31:0] per);
        bus_t b;
        b.busy    = 1'b1;
        b.cs      = 1'b1;
        b.write_n = 1'b0;
        b.addr    = ADDR_STATUS;
        b.wdata   = 16'd0;
        case (s)
            IDLE, RUN: begin
                b.busy    = 1'b0;
                b.cs      = 1'b0;
                b.write_n = 1'b1;
            end
            WR_PL: begin
                b.addr  = ADDR_PERIOD_L;
                b.wdata = per[15:0];
            end
            WR_PH: begin
                b.addr  = ADDR_PERIOD_H;
                b.wdata = per[31:16];
            end
            WR_CTRL: begin
                b.addr  = ADDR_CONTROL;
                b.wdata = CTRL_RUN;
            end
            WR_SNAP: b.addr = ADDR_SNAP_L;
            RD_L: begin
                b.write_n = 1'b1;
                b.addr    = ADDR_SNAP_L;
            end
            RD_H: begin
                b.write_n = 1'b1;
                b.addr    = ADDR_SNAP_H;
            end
            RD_DONE: begin
                b.cs      = 1'b0;
                b.write_n = 1'b1;
            end
            WR_STOP: begin
                b.addr  = ADDR_CONTROL;
                b.wdata = CTRL_STOP;
            end
            default: ;
        endcase
        return b;
    endfunction

    // A cfg_load arriving on the same cycle the sequence starts is used directly
    assign period_nxt = cfg_load ? cfg_period : period_q;

    assign tmr_address    = bus_q.addr;
    assign tmr_chipselect = bus_q.cs;
    assign tmr_write_n    = bus_q.write_n;
    assign tmr_writedata  = bus_q.wdata;
    assign busy           = bus_q.busy;

    // Controller FSM, request latching, tick and snapshot capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bus_q      <= bus_for(IDLE, 32'd0);
            period_q   <= DEFAULT_PERIOD;
            load_pend  <= 1'b0;
            snap_pend  <= 1'b0;
            auto_pend  <= AUTO_START;
            tick       <= 1'b0;
            tick_count <= '0;
            snap_value <= 32'd0;
            snap_valid <= 1'b0;
        end else begin
            tick       <= 1'b0;
            snap_valid <= 1'b0;
            if (cfg_load) begin
                period_q  <= cfg_period;
                load_pend <= 1'b1;
            end
            if (snap_req) begin
                snap_pend <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (enable && (auto_pend || load_pend)) begin
                        state_q   <= WR_PL;
                        bus_q     <= bus_for(WR_PL, period_nxt);
                        load_pend <= 1'b0;
                        auto_pend <= 1'b0;
                    end
                end
                WR_PL: begin
                    state_q <= WR_PH;
                    bus_q   <= bus_for(WR_PH, period_nxt);
                end
                WR_PH: begin
                    state_q <= WR_CTRL;
                    bus_q   <= bus_for(WR_CTRL, period_nxt);
                end
                WR_CTRL: begin
                    state_q <= WR_CLR0;
                    bus_q   <= bus_for(WR_CLR0, period_nxt);
                end
                RUN: begin
                    if (!enable) begin
                        state_q <= WR_STOP;
                        bus_q   <= bus_for(WR_STOP, period_nxt);
                    end else if (load_pend) begin
                        state_q   <= WR_PL;
                        bus_q     <= bus_for(WR_PL, period_nxt);
                        load_pend <= 1'b0;
                    end else if (tmr_irq) begin
                        state_q    <= WR_CLR;
                        bus_q      <= bus_for(WR_CLR, period_nxt);
                        tick       <= 1'b1;
                        tick_count <= tick_count + TICK_CNT_W'(1);
                    end else if (snap_pend) begin
                        state_q   <= WR_SNAP;
                        bus_q     <= bus_for(WR_SNAP, period_nxt);
                        snap_pend <= 1'b0;
                    end
                end
                WR_SNAP: begin
                    state_q <= RD_L;
                    bus_q   <= bus_for(RD_L, period_nxt);
                end
                RD_L: begin
                    state_q <= RD_H;
                    bus_q   <= bus_for(RD_H, period_nxt);
                end
                RD_H: begin
                    state_q          <= RD_DONE;
                    bus_q            <= bus_for(RD_DONE, period_nxt);
                    snap_value[15:0] <= tmr_readdata;
                end
                RD_DONE: begin
                    state_q           <= RUN;
                    bus_q             <= bus_for(RUN, period_nxt);
                    snap_value[31:16] <= tmr_readdata;
                    snap_valid        <= 1'b1;
                end
                WR_STOP: begin
                    state_q <= IDLE;
                    bus_q   <= bus_for(IDLE, period_nxt);
                end
                WR_CLR0, WR_CLR: begin
                    state_q <= RUN;
                    bus_q   <= bus_for(RUN, period_nxt);
                end
                default: begin
                    state_q <= IDLE;
                    bus_q   <= bus_for(IDLE, period_nxt);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systimer_tick_ctrl.sv
// Directed bench for systimer_tick_ctrl with a behavioural interval-timer slave.
module tb_systimer_tick_ctrl;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        enable     = 1'b1;
    logic [31:0] cfg_period = 32'd0;
    logic        cfg_load   = 1'b0;
    logic        snap_req   = 1'b0;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;
    logic        tick;
    logic [31:0] tick_count;
    logic [31:0] snap_value;
    logic        snap_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    systimer_tick_ctrl #(
        .DEFAULT_PERIOD(32'd49999),
        .AUTO_START    (1'b1),
        .TICK_CNT_W    (32)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .cfg_period    (cfg_period),
        .cfg_load      (cfg_load),
        .snap_req      (snap_req),
        .tmr_address   (tmr_address),
        .tmr_chipselect(tmr_chipselect),
        .tmr_write_n   (tmr_write_n),
        .tmr_writedata (tmr_writedata),
        .tmr_readdata  (tmr_readdata),
        .tmr_irq       (tmr_irq),
        .tick          (tick),
        .tick_count    (tick_count),
        .snap_value    (snap_value),
        .snap_valid    (snap_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Interval timer slave: counts down period..0, sets TO at zero and reloads
    logic [31:0] m_period, m_cnt, m_snap;
    logic        m_run, m_cont, m_ito, m_to;
    int          m_to_cnt;
    logic        ovr_en  = 1'b0;
    logic [31:0] ovr_val = 32'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_period <= 32'd0; m_cnt <= 32'd0; m_snap <= 32'd0;
            m_run <= 1'b0; m_cont <= 1'b0; m_ito <= 1'b0; m_to <= 1'b0;
            m_to_cnt <= 0; tmr_readdata <= 16'd0;
        end else begin
            case (tmr_address)
                3'd0:    tmr_readdata <= {14'd0, m_run, m_to};
                3'd4:    tmr_readdata <= m_snap[15:0];
                3'd5:    tmr_readdata <= m_snap[31:16];
                default: tmr_readdata <= 16'd0;
            endcase
            if (m_run) begin
                if (m_cnt == 32'd0) begin
                    m_to     <= 1'b1;
                    m_to_cnt <= m_to_cnt + 1;
                    m_cnt    <= m_period;
                    if (!m_cont) m_run <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 32'd1;
                end
            end
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    3'd0: m_to <= 1'b0;
                    3'd1: begin
                        m_ito  <= tmr_writedata[0];
                        m_cont <= tmr_writedata[1];
                        if (tmr_writedata[2]) m_run <= 1'b1;
                        if (tmr_writedata[3]) m_run <= 1'b0;
                    end
                    3'd2: begin
                        m_period[15:0] <= tmr_writedata;
                        m_cnt <= {m_period[31:16], tmr_writedata};
                        m_run <= 1'b0;
                    end
                    3'd3: begin
                        m_period[31:16] <= tmr_writedata;
                        m_cnt <= {tmr_writedata, m_period[15:0]};
                        m_run <= 1'b0;
                    end
                    3'd4: m_snap <= ovr_en ? ovr_val : m_cnt;
                    default: ;
                endcase
            end
        end
    end
    assign tmr_irq = m_to & m_ito;

    // Bus / tick / snapshot activity log, sampled mid-cycle
    int          w_cyc[$];
    logic [2:0]  w_addr[$];
    logic [15:0] w_data[$];
    int          r_cyc[$];
    logic [2:0]  r_addr[$];
    int          t_cyc[$];
    int          v_cyc[$];
    int          busy_total = 0;

    always @(negedge clk) begin
        if (tmr_chipselect && !tmr_write_n) begin
            w_cyc.push_back(cyc); w_addr.push_back(tmr_address); w_data.push_back(tmr_writedata);
        end
        if (tmr_chipselect && tmr_write_n) begin
            r_cyc.push_back(cyc); r_addr.push_back(tmr_address);
        end
        if (tick)       t_cyc.push_back(cyc);
        if (snap_valid) v_cyc.push_back(cyc);
        if (busy)       busy_total = busy_total + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_load(input logic [31:0] p);
        cfg_period = p;
        cfg_load   = 1'b1;
        step(1);
        cfg_load   = 1'b0;
    endtask

    task automatic test_reset();
        int wb, bb;
        logic [2:0]  ea [4];
        logic [15:0] ed [4];
        ea = '{3'd2, 3'd3, 3'd1, 3'd0};
        ed = '{16'hC34F, 16'h0000, 16'h0007, 16'h0000};
        step(2);
        checks++;
        if ({tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata, tick, snap_valid, busy} !==
            {3'd0, 1'b0, 1'b1, 16'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_bus: got addr=%0d cs=%b wn=%b wd=%h tick=%b sv=%b busy=%b expected 0,0,1,0000,0,0,0",
                     tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata, tick, snap_valid, busy);
        end
        checks++;
        if (tick_count !== 32'd0 || snap_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: got tick_count=%h snap_value=%h expected 0,0", tick_count, snap_value);
        end
        wb = w_cyc.size();
        bb = busy_total;
        reset_n = 1'b1;
        step(10);
        checks++;
        if (w_cyc.size() - wb !== 4) begin
            errors++;
            $display("FAIL start_nwrites: got %0d expected 4", w_cyc.size() - wb);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_addr[wb+i] !== ea[i] || w_data[wb+i] !== ed[i] || w_cyc[wb+i] !== w_cyc[wb] + i) begin
                errors++;
                $display("FAIL start_seq[%0d]: got (%0d,%h) expected (%0d,%h) consecutive",
                         i, w_addr[wb+i], w_data[wb+i], ea[i], ed[i]);
            end
        end
        checks++;
        if (busy_total - bb !== 4) begin
            errors++;
            $display("FAIL start_busy: got %0d busy cycles expected 4", busy_total - bb);
        end
    endtask

    task automatic test_tick_period9();
        int wb, tb, budget, ctrl;
        logic [2:0]  ea [4];
        logic [15:0] ed [4];
        ea = '{3'd2, 3'd3, 3'd1, 3'd0};
        ed = '{16'h0009, 16'h0000, 16'h0007, 16'h0000};
        wb = w_cyc.size();
        tb = t_cyc.size();
        pulse_load(32'd9);
        budget = 0;
        while (t_cyc.size() < tb + 5 && budget < 200) begin
            step(1);
            budget++;
        end
        checks++;
        if (t_cyc.size() < tb + 5) begin
            errors++;
            $display("FAIL p9_timeout: got %0d ticks expected 5", t_cyc.size() - tb);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_addr[wb+i] !== ea[i] || w_data[wb+i] !== ed[i] || w_cyc[wb+i] !== w_cyc[wb] + i) begin
                errors++;
                $display("FAIL p9_seq[%0d]: got (%0d,%h) expected (%0d,%h)",
                         i, w_addr[wb+i], w_data[wb+i], ea[i], ed[i]);
            end
        end
        ctrl = w_cyc[wb+2];
        checks++;
        if (t_cyc[tb] !== ctrl + 12) begin
            errors++;
            $display("FAIL p9_first_tick: got cycle %0d expected %0d", t_cyc[tb], ctrl + 12);
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (t_cyc[tb+i] - t_cyc[tb+i-1] !== 10) begin
                errors++;
                $display("FAIL p9_interval[%0d]: got %0d expected 10", i, t_cyc[tb+i] - t_cyc[tb+i-1]);
            end
        end
        checks++;
        if (tick_count !== 32'd5) begin
            errors++;
            $display("FAIL p9_count: got %0d expected 5", tick_count);
        end
        checks++;
        if (m_to_cnt !== 5) begin
            errors++;
            $display("FAIL p9_one_per_timeout: got %0d timeouts expected 5", m_to_cnt);
        end
    endtask

    task automatic test_reprogram();
        int wb, tb, budget, idx, ctrl;
        logic [2:0]  ea [4];
        logic [15:0] ed [4];
        ea = '{3'd2, 3'd3, 3'd1, 3'd0};
        ed = '{16'h0000, 16'h0001, 16'h0007, 16'h0000};
        wb = w_cyc.size();
        tb = t_cyc.size();
        pulse_load(32'h0001_0000);
        budget = 0;
        while (t_cyc.size() < tb + 1 && budget < 70000) begin
            step(1);
            budget++;
        end
        checks++;
        if (t_cyc.size() < tb + 1) begin
            errors++;
            $display("FAIL reprog_timeout: got no tick within %0d cycles", budget);
        end
        idx = -1;
        for (int i = wb; i < w_cyc.size(); i++)
            if (idx < 0 && w_addr[i] == 3'd2) idx = i;
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL reprog_found: got no period_l write expected one");
            idx = wb;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_addr[idx+i] !== ea[i] || w_data[idx+i] !== ed[i] || w_cyc[idx+i] !== w_cyc[idx] + i) begin
                errors++;
                $display("FAIL reprog_seq[%0d]: got (%0d,%h) expected (%0d,%h)",
                         i, w_addr[idx+i], w_data[idx+i], ea[i], ed[i]);
            end
        end
        ctrl = w_cyc[idx+2];
        checks++;
        if (t_cyc[tb] !== ctrl + 65539) begin
            errors++;
            $display("FAIL reprog_interval: got tick at ctrl+%0d expected ctrl+65539", t_cyc[tb] - ctrl);
        end
        checks++;
        if (tick_count !== 32'd6) begin
            errors++;
            $display("FAIL reprog_count_kept: got %0d expected 6", tick_count);
        end
    endtask

    task automatic test_snapshot();
        int wb, rb, vb, bb, ws, n4;
        ovr_en  = 1'b1;
        ovr_val = 32'h0002_1234;
        wb = w_cyc.size();
        rb = r_cyc.size();
        vb = v_cyc.size();
        bb = busy_total;
        // two requests land while a reprogram is in flight; they collapse to one
        pulse_load(32'h0001_0000);
        snap_req = 1'b1; step(1);
        snap_req = 1'b0; step(1);
        snap_req = 1'b1; step(1);
        snap_req = 1'b0;
        step(20);
        n4 = 0;
        ws = 0;
        for (int i = wb; i < w_cyc.size(); i++)
            if (w_addr[i] == 3'd4) begin
                n4++;
                ws = w_cyc[i];
            end
        checks++;
        if (n4 !== 1) begin
            errors++;
            $display("FAIL snap_collapse: got %0d snapshot writes expected 1", n4);
        end
        checks++;
        if (r_cyc.size() - rb !== 2 || r_addr[rb] !== 3'd4 || r_cyc[rb] !== ws + 1 ||
            r_addr[rb+1] !== 3'd5 || r_cyc[rb+1] !== ws + 2) begin
            errors++;
            $display("FAIL snap_reads: got %0d reads first (%0d @+%0d) expected (4 @+1),(5 @+2)",
                     r_cyc.size() - rb, r_addr[rb], r_cyc[rb] - ws);
        end
        checks++;
        if (v_cyc.size() - vb !== 1 || v_cyc[vb] !== ws + 4) begin
            errors++;
            $display("FAIL snap_valid_time: got %0d pulses first at +%0d expected 1 at +4",
                     v_cyc.size() - vb, v_cyc[vb] - ws);
        end
        checks++;
        if (snap_value !== 32'h0002_1234) begin
            errors++;
            $display("FAIL snap_value: got %h expected 00021234", snap_value);
        end
        checks++;
        if (busy_total - bb !== 8) begin
            errors++;
            $display("FAIL snap_busy: got %0d busy cycles expected 8", busy_total - bb);
        end
    endtask

    task automatic test_back_to_back();
        int tb, budget, t0, ws;
        pulse_load(32'd9);
        tb = t_cyc.size();
        budget = 0;
        while (t_cyc.size() < tb + 1 && budget < 100) begin
            step(1);
            budget++;
        end
        checks++;
        if (t_cyc.size() < tb + 1) begin
            errors++;
            $display("FAIL b2b_sync: got no tick within 100 cycles expected one");
        end
        t0 = cyc;
        ovr_val = 32'h0000_ABCD;
        tb = t_cyc.size();
        step(8);
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
        step(7);
        checks++;
        if (snap_valid !== 1'b1 || snap_value !== 32'h0000_ABCD || tick_count !== 32'd8) begin
            errors++;
            $display("FAIL b2b_result: got sv=%b value=%h count=%0d expected 1,0000abcd,8",
                     snap_valid, snap_value, tick_count);
        end
        step(2);
        ws = -1;
        for (int i = 0; i < w_cyc.size(); i++)
            if (w_addr[i] == 3'd4 && w_cyc[i] > t0) ws = w_cyc[i];
        checks++;
        if (t_cyc[tb] !== t0 + 10 || ws !== t0 + 12) begin
            errors++;
            $display("FAIL b2b_order: got tick +%0d snap write +%0d expected tick +10 then snap +12",
                     t_cyc[tb] - t0, ws - t0);
        end
    endtask

    task automatic test_stop();
        int tb, wb, bb, budget;
        tb = t_cyc.size();
        budget = 0;
        while (t_cyc.size() < tb + 1 && budget < 30) begin
            step(1);
            budget++;
        end
        enable = 1'b0;
        wb = w_cyc.size();
        tb = t_cyc.size();
        bb = busy_total;
        step(30);
        checks++;
        if (w_cyc.size() - wb !== 1 || w_addr[wb] !== 3'd1 || w_data[wb] !== 16'h0008) begin
            errors++;
            $display("FAIL stop_write: got %0d writes first (%0d,%h) expected 1 of (1,0008)",
                     w_cyc.size() - wb, w_addr[wb], w_data[wb]);
        end
        checks++;
        if (busy_total - bb !== 1 || t_cyc.size() !== tb || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: got busy cycles %0d ticks %0d busy=%b expected 1,0,0",
                     busy_total - bb, t_cyc.size() - tb, busy);
        end
    endtask

    task automatic test_reset_mid_snap();
        int wb, budget;
        enable = 1'b1;
        wb = w_cyc.size();
        step(5);
        checks++;
        if (w_cyc.size() !== wb) begin
            errors++;
            $display("FAIL reenable_idle: got %0d writes expected 0", w_cyc.size() - wb);
        end
        pulse_load(32'd9);
        step(8);
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
        budget = 0;
        while (!(tmr_chipselect && tmr_write_n) && budget < 30) begin
            step(1);
            budget++;
        end
        checks++;
        if (!(tmr_chipselect && tmr_write_n)) begin
            errors++;
            $display("FAIL midsnap_reach: got no read cycle within 30 cycles expected one");
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata, tick, snap_valid, busy} !==
            {3'd0, 1'b0, 1'b1, 16'd0, 3'b000} || tick_count !== 32'd0 || snap_value !== 32'd0) begin
            errors++;
            $display("FAIL midsnap_reset: got addr=%0d cs=%b wn=%b count=%0d value=%h busy=%b expected 0,0,1,0,0,0",
                     tmr_address, tmr_chipselect, tmr_write_n, tick_count, snap_value, busy);
        end
        step(2);
        wb = w_cyc.size();
        reset_n = 1'b1;
        step(6);
        checks++;
        if (w_cyc.size() - wb < 1 || w_addr[wb] !== 3'd2 || w_data[wb] !== 16'hC34F) begin
            errors++;
            $display("FAIL restart_default: got (%0d,%h) expected (2,c34f)", w_addr[wb], w_data[wb]);
        end
    endtask

    initial begin
        test_reset();
        test_tick_period9();
        test_reprogram();
        test_snapshot();
        test_back_to_back();
        test_stop();
        test_reset_mid_snap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
